// File: rtl/ysyx_22041071_axi_r_arb.sv
// Two-requester AXI read arbiter (IFU port 0, LSU port 1) feeding one read master.
// Optional: define YSYX_22041071_ARB_RR_EN for round-robin; default is fixed LSU priority.
module ysyx_22041071_axi_r_arb #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int ID_W   = 4,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [1:0]        s_ar_valid,
    output logic [1:0]        s_ar_ready,
    input  logic [ID_W-1:0]   s0_id,
    input  logic [ADDR_W-1:0] s0_addr,
    input  logic [LEN_W-1:0]  s0_len,
    input  logic [1:0]        s0_size,
    input  logic [ID_W-1:0]   s1_id,
    input  logic [ADDR_W-1:0] s1_addr,
    input  logic [LEN_W-1:0]  s1_len,
    input  logic [1:0]        s1_size,
    output logic [1:0]        s_r_valid,
    output logic [DATA_W-1:0] s_r_data,
    output logic [1:0]        s_r_resp,
    output logic              s_r_last,
    output logic              m_ar_valid,
    input  logic              m_ar_ready,
    output logic [ID_W-1:0]   m_id,
    output logic [ADDR_W-1:0] m_addr,
    output logic [LEN_W-1:0]  m_len,
    output logic [1:0]        m_size,
    input  logic              m_r_valid,
    input  logic [DATA_W-1:0] m_r_data,
    input  logic [1:0]        m_r_resp
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ISSUE = 2'd1;
    localparam logic [1:0] WAIT  = 2'd2;

    logic [1:0]       state;
    logic             owner;
    logic [LEN_W-1:0] beat_cnt;
    logic             win;
    logic             accept;
    logic             beat;
    logic             last_beat;

`ifdef YSYX_22041071_ARB_RR_EN
    logic rr_last;

    // Round-robin pick: on a tie the port that did not win last time goes
    always_comb begin
        win = s_ar_valid[1];
        if (&s_ar_valid) begin
            win = ~rr_last;
        end
    end
`else
    // Fixed pick: LSU wins whenever it is requesting
    always_comb begin
        win = s_ar_valid[1];
    end
`endif

    // Handshake and beat routing; everything is forced low while reset is held
    always_comb begin
        accept     = (state == IDLE) && (|s_ar_valid) && !reset;
        beat       = (state == WAIT) && m_r_valid && !reset;
        last_beat  = beat && (beat_cnt == m_len);
        s_ar_ready = 2'b00;
        if (accept) begin
            s_ar_ready = win ? 2'b10 : 2'b01;
        end
        s_r_valid = 2'b00;
        s_r_data  = '0;
        s_r_resp  = 2'b00;
        if (beat) begin
            s_r_valid = owner ? 2'b10 : 2'b01;
            s_r_data  = m_r_data;
            s_r_resp  = m_r_resp;
        end
        s_r_last   = last_beat;
        m_ar_valid = (state == ISSUE) && !reset;
    end

    // Burst sequencing; request fields stay latched until the next accept
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            owner    <= 1'b0;
            beat_cnt <= '0;
            m_id     <= '0;
            m_addr   <= '0;
            m_len    <= '0;
            m_size   <= 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        owner    <= win;
                        beat_cnt <= '0;
                        m_id     <= win ? s1_id   : s0_id;
                        m_addr   <= win ? s1_addr : s0_addr;
                        m_len    <= win ? s1_len  : s0_len;
                        m_size   <= win ? s1_size : s0_size;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (m_ar_ready) begin
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                        if (last_beat) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef YSYX_22041071_ARB_RR_EN
    // Remember the owner of each completed burst for the next tie
    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= 1'b1;
        end else if (last_beat) begin
            rr_last <= owner;
        end
    end
`endif

endmodule

// File: tb/tb_ysyx_22041071_axi_r_arb.sv
// Scoreboard bench for ysyx_22041071_axi_r_arb: random requesters and read
// master, expected per-cycle responses queued by a transaction-level model.
module tb_ysyx_22041071_axi_r_arb;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  s_ar_valid = 2'b00;
    logic [1:0]  s_ar_ready;
    logic [3:0]  s0_id = '0, s1_id = '0;
    logic [63:0] s0_addr = '0, s1_addr = '0;
    logic [7:0]  s0_len = '0, s1_len = '0;
    logic [1:0]  s0_size = '0, s1_size = '0;
    logic [1:0]  s_r_valid;
    logic [63:0] s_r_data;
    logic [1:0]  s_r_resp;
    logic        s_r_last;
    logic        m_ar_valid;
    logic        m_ar_ready = 1'b0;
    logic [3:0]  m_id;
    logic [63:0] m_addr;
    logic [7:0]  m_len;
    logic [1:0]  m_size;
    logic        m_r_valid = 1'b0;
    logic [63:0] m_r_data = '0;
    logic [1:0]  m_r_resp = '0;

    always #5 clk = ~clk;

    ysyx_22041071_axi_r_arb dut (
        .clk(clk), .reset(reset),
        .s_ar_valid(s_ar_valid), .s_ar_ready(s_ar_ready),
        .s0_id(s0_id), .s0_addr(s0_addr), .s0_len(s0_len), .s0_size(s0_size),
        .s1_id(s1_id), .s1_addr(s1_addr), .s1_len(s1_len), .s1_size(s1_size),
        .s_r_valid(s_r_valid), .s_r_data(s_r_data),
        .s_r_resp(s_r_resp), .s_r_last(s_r_last),
        .m_ar_valid(m_ar_valid), .m_ar_ready(m_ar_ready),
        .m_id(m_id), .m_addr(m_addr), .m_len(m_len), .m_size(m_size),
        .m_r_valid(m_r_valid), .m_r_data(m_r_data), .m_r_resp(m_r_resp)
    );

    typedef struct packed {
        logic [3:0]  id;
        logic [63:0] addr;
        logic [7:0]  len;
        logic [1:0]  size;
    } req_t;

    typedef struct {
        logic [1:0]  rdy;
        logic        arv;
        logic        chk_f;
        req_t        f;
        logic [1:0]  rv;
        logic [63:0] data;
        logic [1:0]  resp;
        logic        last;
    } exp_t;

    exp_t        exp_q[$];
    req_t        dq0[$], dq1[$];
    int          dly_q[$];
    logic [63:0] dat_q[$];
    logic [1:0]  rsp_q[$];

    int vectors = 0;
    int miscompares = 0;

    // transaction-level model state
    int   phase = 0;
    int   delay = 0;
    int   left = 0;
    int   grants = 0;
    int   req_pct = 0;
    bit   always_req = 0;
    bit   zero_next = 0;
    logic [1:0] pend = 2'b00;
    logic owner_m = 1'b0;
    logic rr_m = 1'b1;
    req_t rq[2];
    req_t cur;

    function automatic req_t mk(logic [3:0] id, logic [63:0] a,
                                logic [7:0] l, logic [1:0] s);
        req_t r;
        r.id = id; r.addr = a; r.len = l; r.size = s;
        return r;
    endfunction

    function automatic req_t rand_req();
        logic [7:0] l;
        l = ($urandom_range(0, 19) == 0) ? 8'd255 : 8'($urandom_range(0, 7));
        return mk(4'($urandom), {$urandom, $urandom}, l, 2'($urandom));
    endfunction

    // arbitration rule stated directly: who wins among the pending ports
    function automatic logic pick(logic [1:0] v, logic rrl);
`ifdef YSYX_22041071_ARB_RR_EN
        if (v == 2'b11) return (rrl == 1'b0) ? 1'b1 : 1'b0;
        return (v == 2'b10);
`else
        return v[1];
`endif
    endfunction

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] want);
        vectors++;
        if (act !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, want, $time);
        end
    endtask

    // monitor: one expectation record per cycle, compared mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("s_ar_ready", s_ar_ready, e.rdy);
            check("m_ar_valid", m_ar_valid, e.arv);
            check("s_r_valid", s_r_valid, e.rv);
            check("s_r_last", s_r_last, e.last);
            if (e.chk_f) begin
                check("m_id", m_id, e.f.id);
                check("m_addr", m_addr, e.f.addr);
                check("m_len", m_len, e.f.len);
                check("m_size", m_size, e.f.size);
            end
            if (e.rv != 2'b00) begin
                check("s_r_data", s_r_data, e.data);
                check("s_r_resp", s_r_resp, e.resp);
            end
        end
    end

    // one clock of stimulus plus the model's expectation for that clock
    task automatic step(input bit rst);
        exp_t e;
        logic g;
        @(posedge clk);
        #1;
        e = '{default: '0};
        reset      = rst;
        m_ar_ready = 1'($urandom_range(0, 1));
        m_r_valid  = 1'b0;
        m_r_data   = {$urandom, $urandom};
        m_r_resp   = 2'($urandom);
        if (zero_next) begin
            e.chk_f   = 1'b1;
            zero_next = 0;
        end
        if (rst) begin
            pend       = 2'b00;
            s_ar_valid = 2'b00;
            phase      = 0;
            rr_m       = 1'b1;
            zero_next  = 1;
            m_r_valid  = 1'($urandom_range(0, 1));
            exp_q.push_back(e);
            return;
        end
        for (int i = 0; i < 2; i++) begin
            if (!pend[i]) begin
                if (i == 0 && dq0.size() != 0) begin
                    rq[0] = dq0.pop_front();
                    pend[0] = 1'b1;
                end else if (i == 1 && dq1.size() != 0) begin
                    rq[1] = dq1.pop_front();
                    pend[1] = 1'b1;
                end else if (always_req || $urandom_range(0, 99) < req_pct) begin
                    rq[i] = rand_req();
                    pend[i] = 1'b1;
                end
            end
        end
        s_ar_valid = pend;
        {s0_id, s0_addr, s0_len, s0_size} = rq[0];
        {s1_id, s1_addr, s1_len, s1_size} = rq[1];
        case (phase)
            0: begin
                m_r_valid = ($urandom_range(0, 7) == 0);
                if (pend != 2'b00) begin
                    g       = pick(pend, rr_m);
                    e.rdy   = g ? 2'b10 : 2'b01;
                    cur     = rq[g];
                    owner_m = g;
                    pend[g] = 1'b0;
                    phase   = 1;
                    grants++;
                    delay = (dly_q.size() != 0) ? dly_q.pop_front()
                                                : int'($urandom_range(0, 3));
                end
            end
            1: begin
                e.arv     = 1'b1;
                e.chk_f   = 1'b1;
                e.f       = cur;
                m_r_valid = ($urandom_range(0, 7) == 0);
                if (delay == 0) begin
                    m_ar_ready = 1'b1;
                    phase      = 2;
                    left       = int'(cur.len) + 1;
                end else begin
                    m_ar_ready = 1'b0;
                    delay--;
                end
            end
            default: begin
                e.chk_f = 1'b1;
                e.f     = cur;
                if ($urandom_range(0, 2) != 0) begin
                    m_r_valid = 1'b1;
                    if (dat_q.size() != 0) m_r_data = dat_q.pop_front();
                    if (rsp_q.size() != 0) m_r_resp = rsp_q.pop_front();
                    e.rv   = owner_m ? 2'b10 : 2'b01;
                    e.data = m_r_data;
                    e.resp = m_r_resp;
                    e.last = (left == 1);
                    left--;
                    if (left == 0) begin
                        phase = 0;
                        rr_m  = owner_m;
                    end
                end
            end
        endcase
        exp_q.push_back(e);
    endtask

    task automatic run_idle(input int budget);
        int n;
        n = 0;
        while (!(phase == 0 && pend == 2'b00 && dq0.size() == 0 && dq1.size() == 0)) begin
            if (n >= budget) begin
                vectors++;
                miscompares++;
                $display("FAIL idle_timeout: got busy expected idle within %0d cycles", budget);
                return;
            end
            step(0);
            n++;
        end
    endtask

    initial begin
        int n;
        repeat (3) step(1);

        // single IFU read, immediate accept
        dq0.push_back(mk(4'h1, 64'h8000_0004, 8'd0, 2'b10));
        dly_q.push_back(0);
        dat_q.push_back(64'h1122_3344_5566_7788);
        rsp_q.push_back(2'b00);
        run_idle(200);

        // LSU burst of 4 with a slow master and an error beat
        dq1.push_back(mk(4'h2, 64'h8000_1000, 8'd3, 2'b11));
        dly_q.push_back(4);
        for (int i = 0; i < 4; i++) begin
            dat_q.push_back(64'hA0 + 64'(i));
            rsp_q.push_back((i == 2) ? 2'b10 : 2'b00);
        end
        run_idle(200);

        // both ports requesting continuously
        always_req = 1;
        n = grants;
        for (int c = 0; c < 3000 && grants < n + 3; c++) step(0);
        always_req = 0;
        run_idle(3000);

        // random traffic
        req_pct = 30;
        repeat (3000) step(0);
        req_pct = 0;
        run_idle(3000);

        // reset during the second beat of a 4-beat burst
        dq1.push_back(mk(4'h3, 64'h8000_2000, 8'd3, 2'b11));
        n = 0;
        while (!(phase == 2 && left == 3) && n < 400) begin
            step(0);
            n++;
        end
        step(1);
        dq0.push_back(mk(4'h4, 64'h8000_3000, 8'd1, 2'b10));
        dq1.push_back(mk(4'h5, 64'h8000_4000, 8'd0, 2'b01));
        run_idle(300);

        req_pct = 30;
        repeat (500) step(0);
        req_pct = 0;
        run_idle(3000);
        repeat (2) step(0);
        @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
